mem_initiator: RTL and testbench

- Bus master for the byte-wide memory controller. The CPU domain uses it to issue 1-, 2- and 4-byte loads and stores.
- Accepts one request at a time through a valid/ready handshake.
- Sequences the request into single-byte memory strobes (little-endian) and waits the controller's fixed read latency for each read byte.
- Assembles read data and returns one response through a valid/ready handshake.

---
 rtl/mem_initiator.sv | 128 ++++++++++++
 tb/tb_mem_initiator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Byte-serial bus master: splits 1/2/4-byte loads and stores into
// little-endian byte strobes and returns one assembled response.
module mem_initiator #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [7:0]            mem_data_in
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  err;
  logic [1:0]            idx;
  logic [1:0]            last;
  logic [2:0]            cnt;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      write <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      err   <= 1'b0;
      idx   <= '0;
      last  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr  <= req_addr;
            write <= req_write;
            wdata <= req_wdata;
            rdata <= '0;
            idx   <= '0;
            unique case (req_size)
              2'b00:   last <= 2'd0;
              2'b01:   last <= 2'd1;
              default: last <= 2'd3;
            endcase
            if (req_size == 2'b11) begin
              err   <= 1'b1;
              state <= RESP;
            end else begin
              err   <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (write) begin
            if (idx == last) begin
              state <= RESP;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          // final latency cycle: read byte is on mem_data_in now
          if (cnt <= 3'd1) begin
            rdata[{idx, 3'b000} +: 8] <= mem_data_in;
            if (idx == last) begin
              state <= RESP;
            end else begin
              idx   <= idx + 2'd1;
              state <= ISSUE;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rdata <= '0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign issue = !reset && (state == ISSUE);

  assign req_ready    = !reset && (state == IDLE);
  assign rsp_valid    = !reset && (state == RESP);
  assign rsp_rdata    = reset ? 32'd0 : rdata;
  assign rsp_err      = !reset && err;
  assign mem_write_en = issue && write;
  assign mem_read_en  = issue && !write;
  assign mem_addr     = issue ? addr + ADDR_WIDTH'(idx) : '0;
  assign mem_data     = (issue && write) ? wdata[{idx, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: vector table of transactions
// plus backpressure and mid-load reset sequences.
module tb_mem_initiator;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'b00;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [7:0]    mem_data_in;

  mem_initiator #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_in  (mem_data_in)
  );

  always #5 clk = ~clk;

  // memory model, read latency of one cycle
  logic [7:0] mem [0:65535];
  logic [7:0] rd_q = 8'hA5;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_data;
    rd_q <= mem_read_en ? mem[mem_addr] : 8'hA5;
  end
  assign mem_data_in = rd_q;

  int            stb_total = 0;
  logic          both_seen = 1'b0;
  logic [AW-1:0] alog [$];

  always @(negedge clk) begin
    if (mem_write_en || mem_read_en) begin
      stb_total = stb_total + 1;
      alog.push_back(mem_addr);
    end
    if (mem_write_en && mem_read_en) both_seen = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [1:0]    s;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          err;
    int            lat;
    int            nstb;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } vec_t;

  vec_t v [10];

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check("rsp_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic run_vec(input vec_t x, input int k);
    int base;
    int cyc;
    int n;
    @(negedge clk);
    check($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'd1);
    base      = stb_total;
    req_valid = 1'b1;
    req_write = x.w;
    req_addr  = x.a;
    req_size  = x.s;
    req_wdata = x.wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(cyc);
    n = stb_total - base;
    check($sformatf("v%0d_latency", k), 32'(cyc), 32'(x.lat));
    check($sformatf("v%0d_rdata", k), rsp_rdata, x.rd);
    check($sformatf("v%0d_err", k), 32'(rsp_err), 32'(x.err));
    check($sformatf("v%0d_nstrobe", k), 32'(n), 32'(x.nstb));
    if (n > 0) begin
      check($sformatf("v%0d_first_addr", k), 32'(alog[base]), 32'(x.a0));
      check($sformatf("v%0d_last_addr", k), 32'(alog[base+n-1]),
            32'(x.a1));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_done", k), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d_rdata_clr", k), rsp_rdata, 32'd0);
  endtask

  initial begin
    int cyc;
    int base;
    logic seen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    v[0] = '{1'b1, 16'h0010, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0,
             5, 4, 16'h0010, 16'h0013};
    v[1] = '{1'b0, 16'h0010, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0,
             9, 4, 16'h0010, 16'h0013};
    v[2] = '{1'b1, 16'hFFFF, 2'b00, 32'hAAAAAA34, 32'h0, 1'b0,
             2, 1, 16'hFFFF, 16'hFFFF};
    v[3] = '{1'b1, 16'h0000, 2'b00, 32'h55555512, 32'h0, 1'b0,
             2, 1, 16'h0000, 16'h0000};
    v[4] = '{1'b0, 16'hFFFF, 2'b01, 32'h0, 32'h00001234, 1'b0,
             5, 2, 16'hFFFF, 16'h0000};
    v[5] = '{1'b1, 16'h0020, 2'b11, 32'hCAFEF00D, 32'h0, 1'b1,
             1, 0, 16'h0, 16'h0};
    v[6] = '{1'b1, 16'h0100, 2'b01, 32'h55667788, 32'h0, 1'b0,
             3, 2, 16'h0100, 16'h0101};
    v[7] = '{1'b0, 16'h0101, 2'b00, 32'h0, 32'h00000077, 1'b0,
             3, 1, 16'h0101, 16'h0101};
    v[8] = '{1'b0, 16'h0100, 2'b01, 32'h0, 32'h00007788, 1'b0,
             5, 2, 16'h0100, 16'h0101};
    v[9] = '{1'b0, 16'h0010, 2'b11, 32'h0, 32'h0, 1'b1,
             1, 0, 16'h0, 16'h0};

    // reset state
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_strobes", {30'd0, mem_write_en, mem_read_en}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(v[k], k);

    // backpressure: response held, pending request waits
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0010;
    req_size  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_addr = 16'h0011;
    wait_rsp(cyc);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'h000000EF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_hs_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accepted", 32'(req_ready), 32'd0);
    wait_rsp(cyc);
    check("early_ready_latency", 32'(cyc), 32'd3);
    check("early_ready_rdata", rsp_rdata, 32'h000000BE);
    @(posedge clk);
    @(negedge clk);
    check("early_ready_consumed", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // reset during WAIT of byte 2 of a 4-byte load
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0010;
    req_size  = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_in_wait", 32'(mem_read_en), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", {30'd0, mem_write_en, mem_read_en}, 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_req_ready2", 32'(req_ready), 32'd0);
    reset = 1'b0;
    base = stb_total;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("post_rst_no_rsp", 32'(seen), 32'd0);
    check("post_rst_no_strobe", 32'(stb_total - base), 32'd0);
    check("strobe_exclusive", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
